pll_reconfig_master: RTL

//  Avalon-MM initiator that reprograms the core's altera_pll through its altera_pll_reconfig responder:

---
 rtl/pll_cfg_pkg.sv | 33 +++
 rtl/pll_reconfig_master_if.sv | 14 +
 rtl/pll_reconfig_master_sync2.sv | 15 +
 rtl/pll_reconfig_master.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: register map, FSM states and counter-word layout for the PLL reconfig master.
package pll_cfg_pkg;

    localparam int CNT_W = 18;
    localparam int SEL_W = 5;

    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_N      = 6'h03;
    localparam logic [5:0] REG_M      = 6'h04;
    localparam logic [5:0] REG_C      = 6'h05;

    // Write states are consecutive so the FSM can step to the next one by increment.
    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_M, WR_N, WR_C, WR_START, RD_STAT, RD_GAP, WAIT_LOCK, DONE, ERR
    } state_t;

    typedef struct packed {
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } cnt_word_t;

    function automatic logic [5:0] wr_addr(state_t s);
        return s == WR_MODE ? REG_MODE :
               s == WR_M    ? REG_M    :
               s == WR_N    ? REG_N    :
               s == WR_C    ? REG_C    : REG_START;
    endfunction

endpackage

// File: rtl/pll_reconfig_master_if.sv
// pll_reconfig_master_if: Avalon-MM management bus between the master and altera_pll_reconfig.
interface pll_reconfig_master_if;

    logic [5:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, write, read, writedata, input readdata, waitrequest);
    modport slave  (input address, write, read, writedata, output readdata, waitrequest);

endinterface

// File: rtl/pll_reconfig_master_sync2.sv
// sync2: two-flop synchroniser for an asynchronous level, clears to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};

endmodule

// File: rtl/pll_reconfig_master.sv
// pll_reconfig_master: programs M/N/C through altera_pll_reconfig, polls for completion
// and waits for the PLL to relock before reporting done or error.
module pll_reconfig_master
    import pll_cfg_pkg::*;
#(
    parameter int POLL_MAX     = 1023,
    parameter int LOCK_TIMEOUT = 2000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [CNT_W-1:0]      cfg_m,
    input  logic [CNT_W-1:0]      cfg_n,
    input  logic [CNT_W-1:0]      cfg_c,
    input  logic [SEL_W-1:0]      cfg_c_sel,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    input  logic                  pll_locked,
    pll_reconfig_master_if.master mgmt
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    state_t           state;
    cnt_word_t        m_q, n_q, c_q;
    logic [SEL_W-1:0] sel_q;
    logic [PW-1:0]    poll_cnt;
    logic [LW-1:0]    lock_cnt;
    logic [1:0]       stable;
    logic             lock_s;
    logic [31:0]      wr_data;

    sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(pll_locked), .q(lock_s));

    always_comb
        wr_data = state == WR_MODE ? 32'd1 :
                  state == WR_M    ? {14'b0, m_q} :
                  state == WR_N    ? {14'b0, n_q} :
                  state == WR_C    ? {9'b0, sel_q, c_q} : 32'd0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            m_q            <= '0;
            n_q            <= '0;
            c_q            <= '0;
            sel_q          <= '0;
            poll_cnt       <= '0;
            lock_cnt       <= '0;
            stable         <= '0;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            mgmt.address   <= '0;
            mgmt.write     <= 1'b0;
            mgmt.read      <= 1'b0;
            mgmt.writedata <= '0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                IDLE:
                    if (cfg_start) begin
                        m_q      <= cfg_m;
                        n_q      <= cfg_n;
                        c_q      <= cfg_c;
                        sel_q    <= cfg_c_sel;
                        poll_cnt <= '0;
                        cfg_busy <= 1'b1;
                        state    <= WR_MODE;
                    end
                // Strobe is raised on the first cycle of each state, giving one idle cycle between transfers.
                WR_MODE, WR_M, WR_N, WR_C, WR_START:
                    if (!mgmt.write) begin
                        mgmt.write     <= 1'b1;
                        mgmt.address   <= wr_addr(state);
                        mgmt.writedata <= wr_data;
                    end else if (!mgmt.waitrequest) begin
                        mgmt.write <= 1'b0;
                        state      <= state_t'(state + 4'd1);
                    end
                RD_STAT:
                    if (!mgmt.read) begin
                        mgmt.read    <= 1'b1;
                        mgmt.address <= REG_STATUS;
                    end else if (!mgmt.waitrequest) begin
                        mgmt.read <= 1'b0;
                        if (mgmt.readdata[0]) begin
                            lock_cnt <= '0;
                            stable   <= '0;
                            state    <= WAIT_LOCK;
                        end else if (poll_cnt == PW'(POLL_MAX)) begin
                            cfg_err  <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= ERR;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                            state    <= RD_GAP;
                        end
                    end
                RD_GAP: begin
                    mgmt.read    <= 1'b1;
                    mgmt.address <= REG_STATUS;
                    state        <= RD_STAT;
                end
                WAIT_LOCK:
                    if (lock_s && stable == 2'd3) begin
                        cfg_done <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= DONE;
                    end else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                        cfg_err  <= 1'b1;
                        cfg_busy <= 1'b0;
                        state    <= ERR;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                        stable   <= lock_s ? stable + 2'd1 : 2'd0;
                    end
                default: state <= IDLE;
            endcase
        end

endmodule
